// File: rtl/rvc_realign_expand.sv
// Fetch realigner: splits fetch blocks into halfword-aligned instructions, carries
// straddling 32-bit instructions across blocks and expands RVC to 32-bit forms.

module rvc_expand #(
  parameter int XLEN = 64
) (
  input  logic [15:0] i_hw,
  output logic [31:0] o_instr,
  output logic        o_illegal
);
  localparam bit RV64 = (XLEN == 64);
  localparam logic [6:0] OP_IMM = 7'b0010011, OP = 7'b0110011, LOAD = 7'b0000011,
                         STORE = 7'b0100011, LOAD_FP = 7'b0000111, STORE_FP = 7'b0100111;

  logic [31:0] w_ins;
  logic        w_ill;
  logic [4:0]  w_rd, w_rs2, w_rdp, w_rs1p;
  logic [19:0] w_jimm;
  logic [2:0]  w_af3;
  logic        w_imm6_z;

  assign w_rd     = i_hw[11:7];
  assign w_rs2    = i_hw[6:2];
  assign w_rdp    = {2'b01, i_hw[4:2]};
  assign w_rs1p   = {2'b01, i_hw[9:7]};
  assign w_imm6_z = ({i_hw[12], i_hw[6:2]} == 6'd0);
  assign w_jimm   = {i_hw[12], i_hw[8], i_hw[10:9], i_hw[6], i_hw[7], i_hw[2], i_hw[11],
                     i_hw[5:3], i_hw[12], {8{i_hw[12]}}};
  // c.sub/xor/or/and -> 000/100/110/111
  assign w_af3    = (i_hw[6:5] == 2'b00) ? 3'b000 :
                    {1'b1, (i_hw[6:5] == 2'b11) ? 2'b11 : {i_hw[6], 1'b0}};

  always_comb begin
    w_ins = '0;
    w_ill = 1'b0;
    case ({i_hw[1:0], i_hw[15:13]})
      5'b00_000: begin
        w_ins = {2'b0, i_hw[10:7], i_hw[12:11], i_hw[5], i_hw[6], 2'b00, 5'd2, 3'b000, w_rdp, OP_IMM};
        w_ill = (i_hw[12:5] == 8'd0);
      end
      5'b00_001: w_ins = {4'b0, i_hw[6:5], i_hw[12:10], 3'b000, w_rs1p, 3'b011, w_rdp, LOAD_FP};
      5'b00_010: w_ins = {5'b0, i_hw[5], i_hw[12:10], i_hw[6], 2'b00, w_rs1p, 3'b010, w_rdp, LOAD};
      5'b00_011: begin
        w_ins = {4'b0, i_hw[6:5], i_hw[12:10], 3'b000, w_rs1p, 3'b011, w_rdp, LOAD};
        w_ill = !RV64;
      end
      5'b00_101: w_ins = {4'b0, i_hw[6:5], i_hw[12], w_rdp, w_rs1p, 3'b011, i_hw[11:10], 3'b000, STORE_FP};
      5'b00_110: w_ins = {5'b0, i_hw[5], i_hw[12], w_rdp, w_rs1p, 3'b010, i_hw[11:10], i_hw[6], 2'b00, STORE};
      5'b00_111: begin
        w_ins = {4'b0, i_hw[6:5], i_hw[12], w_rdp, w_rs1p, 3'b011, i_hw[11:10], 3'b000, STORE};
        w_ill = !RV64;
      end
      5'b01_000: w_ins = {{7{i_hw[12]}}, i_hw[6:2], w_rd, 3'b000, w_rd, OP_IMM};
      5'b01_001: begin
        if (RV64) begin
          w_ins = {{7{i_hw[12]}}, i_hw[6:2], w_rd, 3'b000, w_rd, 7'b0011011};
          w_ill = (w_rd == 5'd0);
        end else begin
          w_ins = {w_jimm, 5'd1, 7'b1101111};
        end
      end
      5'b01_010: w_ins = {{7{i_hw[12]}}, i_hw[6:2], 5'd0, 3'b000, w_rd, OP_IMM};
      5'b01_011: begin
        if (w_rd == 5'd2)
          w_ins = {{3{i_hw[12]}}, i_hw[4:3], i_hw[5], i_hw[2], i_hw[6], 4'b0, 5'd2, 3'b000, 5'd2, OP_IMM};
        else
          w_ins = {{15{i_hw[12]}}, i_hw[6:2], w_rd, 7'b0110111};
        w_ill = w_imm6_z;
      end
      5'b01_100: begin
        case (i_hw[11:10])
          2'b00: begin
            w_ins = {6'b000000, i_hw[12], i_hw[6:2], w_rs1p, 3'b101, w_rs1p, OP_IMM};
            w_ill = !RV64 && i_hw[12];
          end
          2'b01: begin
            w_ins = {6'b010000, i_hw[12], i_hw[6:2], w_rs1p, 3'b101, w_rs1p, OP_IMM};
            w_ill = !RV64 && i_hw[12];
          end
          2'b10: w_ins = {{7{i_hw[12]}}, i_hw[6:2], w_rs1p, 3'b111, w_rs1p, OP_IMM};
          default: begin
            if (!i_hw[12])
              w_ins = {1'b0, (i_hw[6:5] == 2'b00), 5'b0, w_rdp, w_rs1p, w_af3, w_rs1p, OP};
            else if (RV64 && !i_hw[6])
              w_ins = {1'b0, !i_hw[5], 5'b0, w_rdp, w_rs1p, 3'b000, w_rs1p, 7'b0111011};
            else
              w_ill = 1'b1;
          end
        endcase
      end
      5'b01_101: w_ins = {w_jimm, 5'd0, 7'b1101111};
      5'b01_110, 5'b01_111:
        w_ins = {{4{i_hw[12]}}, i_hw[6:5], i_hw[2], 5'd0, w_rs1p, {2'b00, i_hw[13]},
                 i_hw[11:10], i_hw[4:3], i_hw[12], 7'b1100011};
      5'b10_000: begin
        w_ins = {6'b0, i_hw[12], i_hw[6:2], w_rd, 3'b001, w_rd, OP_IMM};
        w_ill = !RV64 && i_hw[12];
      end
      5'b10_001: w_ins = {3'b0, i_hw[4:2], i_hw[12], i_hw[6:5], 3'b000, 5'd2, 3'b011, w_rd, LOAD_FP};
      5'b10_010: begin
        w_ins = {4'b0, i_hw[3:2], i_hw[12], i_hw[6:4], 2'b00, 5'd2, 3'b010, w_rd, LOAD};
        w_ill = (w_rd == 5'd0);
      end
      5'b10_011: begin
        w_ins = {3'b0, i_hw[4:2], i_hw[12], i_hw[6:5], 3'b000, 5'd2, 3'b011, w_rd, LOAD};
        w_ill = !RV64 || (w_rd == 5'd0);
      end
      5'b10_100: begin
        if (!i_hw[12]) begin
          if (w_rs2 == 5'd0) begin
            w_ins = {12'b0, w_rd, 3'b000, 5'd0, 7'b1100111};
            w_ill = (w_rd == 5'd0);
          end else begin
            w_ins = {7'b0, w_rs2, 5'd0, 3'b000, w_rd, OP};
          end
        end else if (w_rs2 == 5'd0) begin
          w_ins = (w_rd == 5'd0) ? 32'h0010_0073 : {12'b0, w_rd, 3'b000, 5'd1, 7'b1100111};
        end else begin
          w_ins = {7'b0, w_rs2, w_rd, 3'b000, w_rd, OP};
        end
      end
      5'b10_101: w_ins = {3'b0, i_hw[9:7], i_hw[12], w_rs2, 5'd2, 3'b011, i_hw[11:10], 3'b000, STORE_FP};
      5'b10_110: w_ins = {4'b0, i_hw[8:7], i_hw[12], w_rs2, 5'd2, 3'b010, i_hw[11:9], 2'b00, STORE};
      5'b10_111: begin
        w_ins = {3'b0, i_hw[9:7], i_hw[12], w_rs2, 5'd2, 3'b011, i_hw[11:10], 3'b000, STORE};
        w_ill = !RV64;
      end
      default: w_ill = 1'b1;
    endcase
  end

  assign o_illegal = w_ill;
  assign o_instr   = w_ill ? {16'h0, i_hw} : w_ins;
endmodule

module rvc_realign_expand #(
  parameter int FETCH_WIDTH = 32,
  parameter int XLEN        = 64,
  parameter int VLEN        = 64,
  localparam int NR_SLOTS   = FETCH_WIDTH / 16
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               flush_i,
  input  logic                               fetch_valid_i,
  output logic                               fetch_ready_o,
  input  logic [FETCH_WIDTH-1:0]             fetch_data_i,
  input  logic [VLEN-1:0]                    fetch_addr_i,
  output logic [NR_SLOTS-1:0]                instr_valid_o,
  output logic [NR_SLOTS-1:0][31:0]          instr_o,
  output logic [NR_SLOTS-1:0][VLEN-1:0]      addr_o,
  output logic [NR_SLOTS-1:0]                is_compressed_o,
  output logic [NR_SLOTS-1:0]                illegal_o,
  input  logic                               instr_ready_i
);
  localparam int BLK_B = FETCH_WIDTH / 8;
  localparam int OFFW  = $clog2(BLK_B);

  logic [NR_SLOTS-1:0][15:0]     w_hw;
  logic [NR_SLOTS-1:0][31:0]     w_exp, w_pair, w_instr;
  logic [NR_SLOTS-1:0][VLEN-1:0] w_addr, w_oaddr;
  logic [NR_SLOTS-1:0]           w_exp_ill, w_valid, w_comp, w_ill;
  logic [VLEN-1:0]               w_base;
  logic [OFFW-2:0]               w_start;
  logic                          w_skip, w_res_store, w_ready, w_accept;

  logic                          r_res;
  logic [15:0]                   r_res_data;
  logic [VLEN-1:0]               r_res_addr;
  logic [NR_SLOTS-1:0]           r_vld, r_comp, r_ill;
  logic [NR_SLOTS-1:0][31:0]     r_instr;
  logic [NR_SLOTS-1:0][VLEN-1:0] r_addr;

  assign w_hw     = fetch_data_i;
  assign w_base   = fetch_addr_i & ~VLEN'(BLK_B - 1);
  assign w_start  = fetch_addr_i[OFFW-1:1];
  assign w_ready  = !flush_i && (!(|r_vld) || instr_ready_i);
  assign w_accept = fetch_valid_i && w_ready;

  for (genvar k = 0; k < NR_SLOTS; k++) begin : g_slot
    rvc_expand #(.XLEN(XLEN)) u_exp (.i_hw(w_hw[k]), .o_instr(w_exp[k]), .o_illegal(w_exp_ill[k]));
    assign w_addr[k] = w_base + VLEN'(2 * k);
    if (k < NR_SLOTS - 1) begin : g_pair
      assign w_pair[k] = {w_hw[k+1], w_hw[k]};
    end else begin : g_last
      assign w_pair[k] = {16'h0, w_hw[k]};
    end
  end

  // Cursor walk: a held residual consumes halfword 0 and overrides the start offset.
  always_comb begin
    w_valid     = '0;
    w_instr     = '0;
    w_comp      = '0;
    w_ill       = '0;
    w_oaddr     = w_addr;
    w_res_store = 1'b0;
    w_skip      = 1'b0;
    for (int k = 0; k < NR_SLOTS; k++) begin
      if (k == 0 && r_res) begin
        w_valid[0] = 1'b1;
        w_instr[0] = {w_hw[0], r_res_data};
        w_oaddr[0] = r_res_addr;
      end else if (w_skip) begin
        w_skip = 1'b0;
      end else if (r_res || k >= int'(w_start)) begin
        if (w_hw[k][1:0] != 2'b11) begin
          w_valid[k] = 1'b1;
          w_instr[k] = w_exp[k];
          w_comp[k]  = 1'b1;
          w_ill[k]   = w_exp_ill[k];
        end else if (k == NR_SLOTS - 1) begin
          w_res_store = 1'b1;
        end else begin
          w_valid[k] = 1'b1;
          w_instr[k] = w_pair[k];
          w_skip     = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_res      <= 1'b0;
      r_res_data <= '0;
      r_res_addr <= '0;
      r_vld      <= '0;
      r_comp     <= '0;
      r_ill      <= '0;
      r_instr    <= '0;
      r_addr     <= '0;
    end else if (flush_i) begin
      r_res <= 1'b0;
      r_vld <= '0;
    end else begin
      if (w_accept) begin
        r_res <= w_res_store;
        if (w_res_store) begin
          r_res_data <= w_hw[NR_SLOTS-1];
          r_res_addr <= w_base + VLEN'(BLK_B - 2);
        end
      end
      if (w_accept && |w_valid) begin
        r_vld   <= w_valid;
        r_comp  <= w_comp;
        r_ill   <= w_ill;
        r_instr <= w_instr;
        r_addr  <= w_oaddr;
      end else if (instr_ready_i) begin
        r_vld <= '0;
      end
    end
  end

  assign fetch_ready_o   = w_ready;
  assign instr_valid_o   = r_vld;
  assign instr_o         = r_instr;
  assign addr_o          = r_addr;
  assign is_compressed_o = r_comp;
  assign illegal_o       = r_ill;
endmodule

// File: doc/rvc_realign_expand.md
# rvc_realign_expand

Fetch-side stage between the instruction cache/fetch interface and the issue-side decoder. Accepts fetch blocks of FETCH_WIDTH bits, splits them into halfword-aligned instructions, and carries 32-bit instructions that straddle block boundaries across cycles. Expands every RVC instruction to its 32-bit equivalent for the configured XLEN. Presents up to FETCH_WIDTH/16 instructions per cycle through a registered valid/ready output.

## Interface
Parameters:
- FETCH_WIDTH, 32: fetch block width in bits; 32 or 64. NR_SLOTS = FETCH_WIDTH/16.
- XLEN, 64: 32 or 64. Selects RV32 vs RV64 expansion of funct3=001 (C1) and the C0/C2 ld/sd forms.
- VLEN, 64: address width.

Ports:
- clk_i  in  1  clock, all state updates on rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- flush_i  in  1  discard residual halfword and output register.
- fetch_valid_i  in  1  fetch block valid.
- fetch_ready_o  out  1  block accepted when valid && ready.
- fetch_data_i  in  FETCH_WIDTH  little-endian halfwords.
- fetch_addr_i  in  VLEN  byte address of first valid halfword. addr[log2(FETCH_WIDTH/8)-1:1] gives the start halfword; lower halfwords are ignored.
- instr_valid_o  out  NR_SLOTS  per-slot valid.
- instr_o  out  NR_SLOTS×32  expanded instruction per slot.
- addr_o  out  NR_SLOTS×VLEN  byte address of each instruction.
- is_compressed_o  out  NR_SLOTS  source was 16-bit.
- illegal_o  out  NR_SLOTS  illegal RVC encoding.
- instr_ready_i  in  1  consumer takes all valid slots at once.

## Operation
- State: residual valid bit `res_q`, residual halfword `res_data_q[15:0]`, residual address `res_addr_q`, output register (valid vector plus payloads).
- Scan on accept: the cursor starts at the start halfword. If `res_q` is set, halfword 0 completes `{hw0, res_data_q}`. That instruction goes to slot 0 with addr `res_addr_q` and is_compressed=0. The cursor then moves to halfword 1. A start offset is ignored while `res_q` is set.
- At each cursor position, bits[1:0]≠11 means a compressed instruction. It takes 1 halfword and is expanded.
- bits[1:0]=11 with the next halfword in the block forms a 32-bit instruction. It takes 2 halfwords and passes through unchanged.
- bits[1:0]=11 on the last halfword is stored in the residual with its address. `res_q` is set to 1 and the slot is not valid.
- Slot k holds the instruction that starts at halfword k. The straddling instruction uses slot 0. A slot whose halfword continues a 32-bit instruction is invalid.
- Expansion follows the RVC specification:
  - XLEN=32: funct3=001 in C1 maps to c.jal (jal x1). C0/C2 funct3 011/111 are illegal (RV32 F-compressed forms are not supported).
  - XLEN=64: funct3=001 in C1 maps to c.addiw, which is illegal when rd=0.
  - Illegal cases: all-zero and addi4spn with nzimm=0, lui/addi16sp with imm=0, lwsp/ldsp with rd=0, jr with rs1=0, reserved C1 ALU forms, and C0 funct3=100.
- Illegal slot output: illegal_o=1 and instr_o={16'h0, raw halfword}.
- Byte addresses: slot k = fetch_addr aligned down to the block, plus 2k. `res_addr_q` = block base + FETCH_WIDTH/8 − 2. All address arithmetic wraps modulo 2^VLEN.
- A block with no valid slot (only a residual stored) does not load the output register and does not set its valid.
- flush_i: next cycle `res_q`=0 and instr_valid_o=0. Any block presented in the same cycle is dropped. Flush has priority over acceptance.

## Timing
- Reset (rst_ni=0 at edge): instr_valid_o=0, res_q=0, all payload outputs 0. fetch_ready_o=1 in the first cycle after reset.
- fetch_ready_o = !flush_i && (!(|instr_valid_o) || instr_ready_i). This is combinational, so there is no bubble under continuous ready.
- Latency: a block accepted at edge N appears on the outputs after edge N.
- Throughput: 1 block per cycle.
- Outputs are held stable while |instr_valid_o && !instr_ready_i.
- A straddling instruction appears in the cycle after its second half is accepted. `res_q` persists indefinitely while no block arrives.
- Reset mid-operation discards the residual and output regardless of the handshake.

## Test plan
- FETCH_WIDTH=32, XLEN=64. Block 0x4501_0505 @0x8000_0000 → slot0 0x0015_0513 @0x8000_0000 (c=1), slot1 0x0000_0513 @0x8000_0002 (c=1).
- Straddle. Block 0x0513_0505 @0x8000_0000 → slot0 0x0015_0513 only, res_q=1. Then block 0x4501_0015 @0x8000_0004 → slot0 0x0015_0513 @0x8000_0002 (c=0), slot1 0x0000_0513 @0x8000_0006.
- Mode and illegal:
  - XLEN=32, halfword 0x2005 → 0x0200_00EF (jal x1,32).
  - XLEN=64, same halfword → illegal_o=1, instr_o=0x0000_2005.
  - 0x0000 → illegal, instr_o=0.
- Backpressure: instr_ready_i=0 for 3 cycles with a valid output → outputs unchanged, fetch_ready_o=0. Ready=1 → next block loads on the same edge.
- Flush with res_q=1, block presented in the same cycle → nothing accepted. The next block 0x4501_0505 decodes fresh: slot0 0x0015_0513.
- Start offset: fetch_addr 0x8000_0002, FETCH_WIDTH=64 → slot0 invalid, decoding starts at halfword 1. Also synchronous reset asserted mid-straddle → all outputs 0, residual lost.
